alu_exec_unit: RTL and testbench

Execute-stage ALU that sits directly downstream of the ALU control decoder and consumes its 4-bit ALU_Control code together with the two register operands. Single-cycle codes (add, sub, and, or, slt, nor) return a registered result one cycle after acceptance. Iterative multu/divu codes write the HI/LO registers over WIDTH cycles; mfhi/mflo read them back. A valid/ready handshake lets the datapath stall while a multi-cycle operation is in flight.

---
 rtl/alu_exec_unit.sv | 115 +++++++++++
 tb/tb_alu_exec_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with registered single-cycle ops and iterative multu/divu into HI/LO.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALU_Control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] op_q, op_d, hi_q, hi_d, lo_q, lo_d, result_q, result_d, alu, rem_sub;
  logic [2*WIDTH-1:0] w_q, w_d, mul_next, div_next, iter;
  logic [WIDTH:0] sum, rem_sh;
  logic zero_q, zero_d, out_valid_q, out_valid_d, ge, last;
  always_comb begin
    case (ALU_Control)
      4'b0010: alu = a + b;
      4'b0110: alu = a - b;
      4'b0000: alu = a & b;
      4'b0001: alu = a | b;
      4'b0111: alu = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      4'b1100: alu = ~(a | b);
      4'b1010: alu = hi_q;
      4'b1011: alu = lo_q;
      default: alu = '0;
    endcase
  end
  // w_q holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
  always_comb begin
    sum      = {1'b0, w_q[2*WIDTH-1:WIDTH]} + {1'b0, op_q & {WIDTH{w_q[0]}}};
    mul_next = {sum, w_q[WIDTH-1:1]};
    rem_sh   = w_q[2*WIDTH-1:WIDTH-1];
    ge       = rem_sh >= {1'b0, op_q};
    rem_sub  = rem_sh[WIDTH-1:0] - op_q;
    div_next = {ge ? rem_sub : rem_sh[WIDTH-1:0], w_q[WIDTH-2:0], ge};
    iter     = state_q == MUL ? mul_next : div_next;
    last     = cnt_q == CW'(WIDTH - 1);
  end
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    w_d         = w_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = 1'b0;
    if (state_q == IDLE && in_valid) begin
      if (ALU_Control[3:1] == 3'b100) begin
        state_d = ALU_Control[0] ? DIV : MUL;
        op_d    = ALU_Control[0] ? b : a;
        w_d     = {{WIDTH{1'b0}}, ALU_Control[0] ? a : b};
        cnt_d   = '0;
      end else begin
        result_d    = alu;
        zero_d      = alu == '0;
        out_valid_d = 1'b1;
      end
    end else if (state_q == MUL || state_q == DIV) begin
      w_d   = iter;
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        state_d     = DONE;
        hi_d        = iter[2*WIDTH-1:WIDTH];
        lo_d        = iter[WIDTH-1:0];
        result_d    = iter[WIDTH-1:0];
        zero_d      = iter[WIDTH-1:0] == '0;
        out_valid_d = 1'b1;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      w_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      w_q         <= w_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: scoreboard bench; issue side predicts results and timing, negedge monitor compares.
module tb_alu_exec_unit;
  localparam int W = 32;
  logic clk = 1'b0;
  logic reset, in_valid, in_ready, out_valid, zero;
  logic [3:0] ctl;
  logic [W-1:0] a, b, result, hi, lo;
  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           cyc;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;
  int cyc = 0, npass = 0, ntot = 0, nov = 0, next_ok = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic [3:0] codes [10] = '{4'h2, 4'h6, 4'h0, 4'h1, 4'h7, 4'hC, 4'h8, 4'h9, 4'hA, 4'hB};

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALU_Control(ctl), .a(a), .b(b), .out_valid(out_valid),
    .result(result), .zero(zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s at cycle %0d: got %h required %h", nm, cyc, got, exp);
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      nov++;
      if (q.size() == 0) begin
        ntot++;
        $display("FAIL unexpected_out_valid at cycle %0d: got result %h required no output", cyc, result);
      end else begin
        mon_e = q.pop_front();
        chk("result", 64'(result), 64'(mon_e.res));
        chk("zero", 64'(zero), 64'(mon_e.z));
        chk("hi", 64'(hi), 64'(mon_e.hi));
        chk("lo", 64'(lo), 64'(mon_e.lo));
        chk("out_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 4))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
    int acc, n;
    exp_t e;
    logic [2*W-1:0] p;
    bit multi;
    multi = (c == 4'h8) || (c == 4'h9);
    acc = (cyc + 1 > next_ok) ? cyc + 1 : next_ok;
    in_valid = 1'b1; ctl = c; a = x; b = y; n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      ntot++;
      $display("FAIL accept_timeout: got in_ready 0 required 1");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; ctl = 4'($urandom);
    chk("accept_cycle", 64'(cyc), 64'(acc));
    e.res = '0;
    case (c)
      4'h2: e.res = x + y;
      4'h6: e.res = x - y;
      4'h0: e.res = x & y;
      4'h1: e.res = x | y;
      4'h7: e.res = ($signed(x) < $signed(y)) ? 1 : 0;
      4'hC: e.res = ~(x | y);
      4'h8: begin
        p = 64'(x) * 64'(y);
        m_hi = p[63:32];
        m_lo = p[31:0];
        e.res = m_lo;
      end
      4'h9: begin
        if (y == 0) begin
          m_lo = '1;
          m_hi = x;
        end else begin
          m_lo = x / y;
          m_hi = x % y;
        end
        e.res = m_lo;
      end
      4'hA: e.res = m_hi;
      4'hB: e.res = m_lo;
      default: e.res = '0;
    endcase
    e.z = e.res == 0;
    e.hi = m_hi;
    e.lo = m_lo;
    e.cyc = acc + (multi ? W : 0);
    q.push_back(e);
    next_ok = multi ? acc + W + 2 : acc + 1;
    @(negedge clk);
  endtask

  initial begin
    int n, n0;
    reset = 1'b1; in_valid = 1'b0; ctl = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_zero", 64'(zero), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    issue(4'h2, 5, 7);
    issue(4'h6, 9, 9);
    issue(4'h7, '1, 1);
    issue(4'hC, 0, 0);
    issue(4'h0, 32'hF0F0, 32'h0FF0);
    issue(4'hF, $urandom, $urandom);
    issue(4'h8, '1, 2);
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("busy_cycles", 64'(n), 64'(W + 1));
    issue(4'hA, 0, 0);
    issue(4'h9, 100, 7);
    issue(4'hB, 0, 0);
    issue(4'h9, 100, 0);
    issue(4'hA, 0, 0);
    issue(4'h8, $urandom, $urandom);
    issue(4'h2, 3, 4);
    for (int i = 0; i < 40; i++) begin
      logic [3:0] c;
      c = ($urandom_range(0, 10) == 10) ? 4'($urandom) : codes[$urandom_range(0, 9)];
      issue(c, rnd_op(), rnd_op());
    end
    issue(4'h9, 32'hDEAD_BEEF, 32'h1234);
    issue(4'h8, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0; next_ok = 0;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    n0 = nov;
    repeat (40) @(negedge clk);
    chk("abort_no_output", 64'(nov - n0), 64'd0);
    issue(4'hB, 0, 0);
    issue(4'h6, 1, 2);
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
